// File: rtl/bm_rng_core.sv
// Gaussian-approximating RNG: taus88 uniform source shaped by a four-lane central-limit sum,
// with every flop (s1, s2, s3, g) on a single 107-bit scan chain.
module bm_rng_core #(
    parameter logic [31:0] SEED1 = 32'hDEADBEEF,
    parameter logic [31:0] SEED2 = 32'h0BADF00D,
    parameter logic [31:0] SEED3 = 32'hCAFEBABE
) (
    input  logic clk,
    input  logic reset,
    input  logic scan_in0,
    input  logic scan_en,
    input  logic test_mode,
    output logic scan_out0
);

    typedef enum logic [1:0] {
        MODE_RESET,
        MODE_SHIFT,
        MODE_UPDATE
    } mode_t;

    mode_t       mode;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] s3;
    logic [10:0] g;

    logic [31:0] u;
    logic [31:0] s1_next;
    logic [31:0] s2_next;
    logic [31:0] s3_next;
    logic [10:0] lane_sum;
    logic [10:0] sample;

    function automatic logic [31:0] taus_step(
        input logic [31:0] s,
        input logic [31:0] mask,
        input int unsigned sh_a,
        input int unsigned sh_b,
        input int unsigned sh_c
    );
        logic [31:0] b;
        b = ((s << sh_b) ^ s) >> sh_c;
        return ((s & ~mask) << sh_a) ^ b;
    endfunction

    always_comb begin
        if (!reset) begin
            mode = MODE_RESET;
        end else if (test_mode && scan_en) begin
            mode = MODE_SHIFT;
        end else begin
            mode = MODE_UPDATE;
        end
    end

    always_comb begin
        u        = s1 ^ s2 ^ s3;
        s1_next  = taus_step(s1, 32'h0000_0001, 12, 13, 19);
        s2_next  = taus_step(s2, 32'h0000_0007, 4, 2, 25);
        s3_next  = taus_step(s3, 32'h0000_000F, 17, 3, 11);
        // Four bytes sum to at most 1020, so the 11-bit wrap of the -510 offset is exact two's complement.
        lane_sum = 11'(u[31:24]) + 11'(u[23:16]) + 11'(u[15:8]) + 11'(u[7:0]);
        sample   = lane_sum - 11'd510;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        unique case (mode)
            MODE_RESET: begin
                s1 <= SEED1;
                s2 <= SEED2;
                s3 <= SEED3;
                g  <= '0;
            end
            MODE_SHIFT: begin
                s1 <= {scan_in0, s1[31:1]};
                s2 <= {s1[0], s2[31:1]};
                s3 <= {s2[0], s3[31:1]};
                g  <= {s3[0], g[10:1]};
            end
            default: begin
                s1 <= s1_next;
                s2 <= s2_next;
                s3 <= s3_next;
                g  <= sample;
            end
        endcase
    end

    assign scan_out0 = test_mode ? g[0] : g[10];

endmodule

// File: tb/tb_bm_rng_core.sv
// Directed self-checking bench for bm_rng_core: reset, scan shift/dump, capture, and a long
// functional run compared against an independent taus88 reference model.
module tb_bm_rng_core;

    localparam logic [31:0] SEED1 = 32'hDEADBEEF;
    localparam logic [31:0] SEED2 = 32'h0BADF00D;
    localparam logic [31:0] SEED3 = 32'hCAFEBABE;

    logic clk;
    logic reset;
    logic scan_in0;
    logic scan_en;
    logic test_mode;
    logic scan_out0;

    int vec_count = 0;
    int miscompares = 0;

    bm_rng_core #(
        .SEED1(SEED1),
        .SEED2(SEED2),
        .SEED3(SEED3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .scan_in0 (scan_in0),
        .scan_en  (scan_en),
        .test_mode(test_mode),
        .scan_out0(scan_out0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Shifts 107 bits: out_vec[i] is the chain tail seen before edge i, in_vec[i] is driven into it.
    task automatic shift_chain(input logic [106:0] in_vec, output logic [106:0] out_vec);
        test_mode = 1'b1;
        scan_en   = 1'b1;
        #1;
        for (int i = 0; i < 107; i++) begin
            out_vec[i] = scan_out0;
            scan_in0   = in_vec[i];
            step();
        end
        scan_en  = 1'b0;
        scan_in0 = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    // Reference taus88, written in the C form of the generator.
    function automatic logic [31:0] ref_s1(input logic [31:0] s);
        logic [31:0] b;
        b = ((s << 13) ^ s) >> 19;
        return ((s & 32'hFFFF_FFFE) << 12) ^ b;
    endfunction

    function automatic logic [31:0] ref_s2(input logic [31:0] s);
        logic [31:0] b;
        b = ((s << 2) ^ s) >> 25;
        return ((s & 32'hFFFF_FFF8) << 4) ^ b;
    endfunction

    function automatic logic [31:0] ref_s3(input logic [31:0] s);
        logic [31:0] b;
        b = ((s << 3) ^ s) >> 11;
        return ((s & 32'hFFFF_FFF0) << 17) ^ b;
    endfunction

    function automatic logic [10:0] ref_sample(input logic [31:0] a, input logic [31:0] b,
                                                input logic [31:0] c);
        logic [31:0] x;
        int          total;
        x     = a ^ b ^ c;
        total = int'(x[31:24]) + int'(x[23:16]) + int'(x[15:8]) + int'(x[7:0]) - 510;
        return total[10:0];
    endfunction

    initial begin
        logic [106:0] dump;
        logic [106:0] pattern;
        logic [10:0]  g_exp;
        logic [10:0]  smp;
        logic [31:0]  m1, m2, m3;
        logic         prev_sign;
        int           neg_count;
        int           toggles;

        reset     = 1'b0;
        scan_in0  = 1'b0;
        scan_en   = 1'b0;
        test_mode = 1'b0;

        // Long reset hold: output stays low in both modes.
        for (int i = 0; i < 1000; i++) begin
            step();
            check("rst_hold", scan_out0, 1'b0);
        end
        test_mode = 1'b1;
        #1;
        check("rst_hold_tm", scan_out0, 1'b0);
        test_mode = 1'b0;

        // First functional sample from the seeds, then read g out LSB first.
        reset = 1'b1;
        step();
        check("first_sign", scan_out0, 1'b0);
        g_exp     = 11'h06F;
        test_mode = 1'b1;
        scan_en   = 1'b1;
        #1;
        for (int i = 0; i < 11; i++) begin
            check($sformatf("first_g_bit%0d", i), scan_out0, g_exp[i]);
            step();
        end
        scan_en = 1'b0;

        // Full dump straight after reset: g zeros then the seeds, zeros shifted in behind.
        apply_reset();
        shift_chain('0, dump);
        check("seed_head", dump[14:0], 15'h7000);
        check("seed_dump", dump, {SEED1, SEED2, SEED3, 11'h000});

        // All-zero state; scan_en with test_mode=0 must not shift.
        test_mode = 1'b0;
        scan_en   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            check("zero_state_sign", scan_out0, 1'b1);
        end
        scan_en = 1'b0;
        shift_chain('0, dump);
        check("zero_state_dump", dump, {96'h0, 11'h602});

        // Reset in the middle of a shift.
        test_mode = 1'b1;
        scan_en   = 1'b1;
        scan_in0  = 1'b1;
        for (int i = 0; i < 50; i++) step();
        reset = 1'b0;
        step();
        check("rst_mid_shift_tm", scan_out0, 1'b0);
        test_mode = 1'b0;
        #1;
        check("rst_mid_shift_fn", scan_out0, 1'b0);
        reset    = 1'b1;
        scan_in0 = 1'b0;
        shift_chain('0, dump);
        check("rst_mid_shift_dump", dump, {SEED1, SEED2, SEED3, 11'h000});

        // Reset in the middle of a functional run.
        apply_reset();
        test_mode = 1'b0;
        for (int i = 0; i < 20; i++) step();
        reset = 1'b0;
        step();
        check("rst_mid_run", scan_out0, 1'b0);
        reset = 1'b1;
        shift_chain('0, dump);
        check("rst_mid_run_dump", dump, {SEED1, SEED2, SEED3, 11'h000});

        // Arbitrary (including illegal) state: round trip, then one capture cycle.
        pattern = {32'h0000_0001, 32'h1234_5678, 32'h89AB_CDEF, 11'h5A5};
        shift_chain(pattern, dump);
        shift_chain(pattern, dump);
        check("roundtrip", dump, pattern);
        test_mode = 1'b1;
        scan_en   = 1'b0;
        step();
        shift_chain('0, dump);
        check("capture", dump, {ref_s1(32'h0000_0001), ref_s2(32'h1234_5678),
                                ref_s3(32'h89AB_CDEF),
                                ref_sample(32'h0000_0001, 32'h1234_5678, 32'h89AB_CDEF)});

        // Long functional run from reset against the reference model.
        apply_reset();
        test_mode = 1'b0;
        m1        = SEED1;
        m2        = SEED2;
        m3        = SEED3;
        neg_count = 0;
        toggles   = 0;
        prev_sign = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            smp = ref_sample(m1, m2, m3);
            m1  = ref_s1(m1);
            m2  = ref_s2(m2);
            m3  = ref_s3(m3);
            step();
            check($sformatf("run_sign%0d", i), scan_out0, smp[10]);
            if (scan_out0 === 1'b1) neg_count++;
            if (i > 0 && scan_out0 !== prev_sign) toggles++;
            prev_sign = scan_out0;
        end
        check("neg_fraction", (neg_count >= 4700 && neg_count <= 5300), 1'b1);
        check("sign_toggles", (toggles > 0), 1'b1);
        shift_chain('0, dump);
        check("run_state_dump", dump, {m1, m2, m3, smp});

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
